// File: rtl/dbg_bus_master.sv
// Debug-unit Wishbone slave to multiplexed system-bus master, one single-beat transaction per cycle.
// Optional data-wait timeout is enabled by defining DBG_BUS_TIMEOUT_EN.
module dbg_bus_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        system_clock,
    input  logic        system_reset_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        request,
    input  logic        transactionGranted,
    output logic [31:0] address_dataOUT,
    output logic [3:0]  byte_enablesOUT,
    output logic [7:0]  burstSizeOUT,
    output logic        read_n_writeOUT,
    output logic        begin_transactionOUT,
    output logic        end_transactionOUT,
    output logic        data_validOUT,
    output logic        busyOUT,
    input  logic [31:0] address_dataIN,
    input  logic        end_transactionIN,
    input  logic        data_validIN,
    input  logic        busyIN,
    input  logic        errorIN
);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_BEGIN, S_WDATA, S_WEND, S_RWAIT, S_ABORT, S_ACK, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d, wdat_q, wdat_d, rdata_q, rdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d, got_data_q, got_data_d, abandon_q, abandon_d;
    logic        request_q, request_d, begin_q, begin_d, end_q, end_d;
    logic        dvalid_q, dvalid_d, rnw_q, rnw_d, ack_q, ack_d, err_q, err_d;
    logic [31:0] ad_out_q, ad_out_d;
    logic [3:0]  be_q, be_d;
    logic        expired;

    if (TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_timeout_w
        $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

`ifdef DBG_BUS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter is zero in the first wait cycle, so expiry at N-1 ends the wait after N cycles.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_WDATA || state_q == S_RWAIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) tmo_cnt_q <= '0;
        else                 tmo_cnt_q <= tmo_cnt_d;
    end

    assign expired = (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        got_data_d = got_data_q;
        abandon_d  = abandon_q;

        case (state_q)
            S_IDLE: if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
                adr_d      = wb_adr_i;
                wdat_d     = wb_dat_i;
                sel_d      = wb_sel_i;
                we_d       = wb_we_i;
                got_data_d = 1'b0;
                abandon_d  = 1'b0;
                state_d    = S_REQ;
            end
            S_REQ:   if (transactionGranted) state_d = S_BEGIN;
            S_BEGIN: state_d = we_q ? S_WDATA : S_RWAIT;
            S_WDATA: begin
                if (errorIN)      state_d = S_ABORT;
                else if (!busyIN) state_d = S_WEND;
                else if (expired) state_d = S_ABORT;
            end
            S_WEND:  state_d = S_ACK;
            S_RWAIT: begin
                if (errorIN) begin
                    state_d = S_ERR;
                end else begin
                    if (data_validIN) begin
                        rdata_d    = address_dataIN;
                        got_data_d = 1'b1;
                    end
                    if (end_transactionIN)
                        state_d = (data_validIN || got_data_q) ? S_ACK : S_ERR;
                    else if (expired)
                        state_d = S_ABORT;
                end
            end
            S_ABORT: state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !wb_cyc_i) abandon_d = 1'b1;

        // Outputs are decoded from the next state so every bus output comes straight from a flop.
        request_d = 1'b0;
        begin_d   = 1'b0;
        end_d     = 1'b0;
        dvalid_d  = 1'b0;
        rnw_d     = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        ad_out_d  = '0;
        be_d      = '0;
        case (state_d)
            S_REQ:   request_d = 1'b1;
            S_BEGIN: begin
                begin_d  = 1'b1;
                ad_out_d = adr_q;
                be_d     = sel_q;
                rnw_d    = ~we_q;
            end
            S_WDATA: begin
                ad_out_d = wdat_q;
                dvalid_d = 1'b1;
            end
            S_WEND, S_ABORT: end_d = 1'b1;
            S_ACK:   ack_d = ~abandon_d;
            S_ERR:   err_d = ~abandon_d;
            default: ;
        endcase
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            wdat_q     <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            got_data_q <= 1'b0;
            abandon_q  <= 1'b0;
            request_q  <= 1'b0;
            begin_q    <= 1'b0;
            end_q      <= 1'b0;
            dvalid_q   <= 1'b0;
            rnw_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            ad_out_q   <= '0;
            be_q       <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            got_data_q <= got_data_d;
            abandon_q  <= abandon_d;
            request_q  <= request_d;
            begin_q    <= begin_d;
            end_q      <= end_d;
            dvalid_q   <= dvalid_d;
            rnw_q      <= rnw_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            ad_out_q   <= ad_out_d;
            be_q       <= be_d;
        end
    end

    assign wb_dat_o             = rdata_q;
    assign wb_ack_o             = ack_q;
    assign wb_err_o             = err_q;
    assign request              = request_q;
    assign address_dataOUT      = ad_out_q;
    assign byte_enablesOUT      = be_q;
    assign burstSizeOUT         = '0;
    assign read_n_writeOUT      = rnw_q;
    assign begin_transactionOUT = begin_q;
    assign end_transactionOUT   = end_q;
    assign data_validOUT        = dvalid_q;
    assign busyOUT              = 1'b0;

endmodule

// File: doc/dbg_bus_master.md
Name: dbg_bus_master

Overview:
- Sequences debug-unit Wishbone accesses onto the shared multiplexed address/data system bus.
- Sits between the debug-unit Wishbone master port and the system bus arbiter.
- Each Wishbone cycle becomes one single-beat bus transaction: request, wait for grant, begin, data, end.
- The completion status is returned to the debug unit as wb_ack_o or wb_err_o.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles allowed in a data wait before the access is aborted (only used when DBG_BUS_TIMEOUT_EN is defined).
TIMEOUT_W, 8, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
system_clock  in  1  single clock for all logic.
system_reset_n  in  1  asynchronous active-low reset.
wb_adr_i  in  32  Wishbone byte address.
wb_dat_i  in  32  Wishbone write data.
wb_sel_i  in  4  byte selects.
wb_we_i  in  1  1 = write.
wb_cyc_i  in  1  cycle valid.
wb_stb_i  in  1  strobe.
wb_dat_o  out  32  read data.
wb_ack_o  out  1  one-cycle completion pulse.
wb_err_o  out  1  one-cycle error pulse.
request  out  1  bus request to the arbiter.
transactionGranted  in  1  grant from the arbiter.
address_dataOUT  out  32  multiplexed address/data.
byte_enablesOUT  out  4  byte enables.
burstSizeOUT  out  8  beats minus 1; always 0.
read_n_writeOUT  out  1  1 = read.
begin_transactionOUT  out  1  begin strobe.
end_transactionOUT  out  1  end strobe.
data_validOUT  out  1  write data valid.
busyOUT  out  1  always 0; never stalls a slave.
address_dataIN  in  32  read data from the bus.
end_transactionIN  in  1  slave end strobe.
data_validIN  in  1  read data valid.
busyIN  in  1  slave busy.
errorIN  in  1  slave error.

Behaviour:
- Reset (asynchronous, system_reset_n=0): every output is 0 and the FSM is in IDLE. Reset mid-transaction abandons it with no end strobe; the arbiter is expected to recover.
- FSM states and transitions:
  - IDLE: when wb_cyc_i & wb_stb_i are high and no ack/err is pending, latch adr/dat/sel/we. Next cycle assert request and go to REQ.
  - REQ: hold request until transactionGranted=1, then go to BEGIN.
  - BEGIN: for exactly one cycle drive begin_transactionOUT=1, address_dataOUT=latched address, byte_enablesOUT=sel, read_n_writeOUT=~we, burstSizeOUT=0. Drop request. Go to WDATA if write, RWAIT if read.
  - WDATA: drive address_dataOUT=write data and data_validOUT=1. The beat is accepted on the first cycle with busyIN=0. While busyIN=1, hold data and data_validOUT unchanged. On acceptance go to WEND.
  - WEND: for one cycle drive end_transactionOUT=1 with all other bus outputs 0. Go to ACK.
  - RWAIT: on data_validIN=1, capture address_dataIN into wb_dat_o. After capture, go to ACK on end_transactionIN=1; end_transactionIN and data_validIN in the same cycle is legal.
  - ACK: pulse wb_ack_o for one cycle, then return to IDLE.
- Error handling:
  - errorIN=1 in WDATA or RWAIT: go to ERR and assert end_transactionOUT for one cycle (write case only; in the read case the slave ends the transaction).
  - end_transactionIN=1 in RWAIT before any data_validIN: treated as an error.
  - ERR: pulse wb_err_o for one cycle, leave wb_dat_o unchanged, return to IDLE.
- Wishbone rules:
  - Ack/err go high one cycle after the bus transaction completes.
  - Worst-case write latency from stb to ack, with immediate grant and busyIN=0: 5 cycles.
  - If wb_cyc_i drops mid-transaction, the bus transaction still completes and the ack/err pulse is suppressed.
- Output gating: address_dataOUT is 0 in every state other than BEGIN and WDATA, so outputs can be wire-ORed on the shared bus.

Optional Feature:
DBG_BUS_TIMEOUT_EN:
- Defined: a TIMEOUT_W-bit counter clears on entry to WDATA/RWAIT and increments each cycle spent there. When it reaches TIMEOUT_CYCLES:
  - assert end_transactionOUT for one cycle;
  - go to ERR (wb_err_o pulse).
  - A completion in the same cycle as expiry wins over the timeout.
- Undefined: the counter is absent and the FSM waits indefinitely.

Test Plan:
- Write 0xDEADBEEF to 0x00001000, sel=0xF, grant after 3 cycles, busyIN=0:
  - begin with address 0x00001000 and read_n_write=0;
  - next cycle data 0xDEADBEEF with data_valid;
  - end strobe, then a single wb_ack_o pulse.
- Read 0x00002000; slave returns data_validIN with 0x12345678 and end_transactionIN 2 cycles after begin -> wb_dat_o=0x12345678 and one ack.
- Write with busyIN high for 4 cycles -> data_validOUT stays high with data stable for 5 cycles, then end and ack.
- Read with errorIN on the second wait cycle -> wb_err_o pulse, no ack, wb_dat_o unchanged, FSM back in IDLE.
- With DBG_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, a read where the slave never responds:
  - end_transactionOUT 8 cycles after entering RWAIT;
  - wb_err_o 1 cycle later.
- Deassert system_reset_n during WDATA -> all outputs 0 immediately; the next Wishbone write completes normally.
